// File: rtl/boot_loader_ctrl.sv
// Boot controller: assembles a little-endian word stream into instruction memory,
// verifies an XOR checksum, then releases the core from reset.
module boot_loader_ctrl #(
   parameter int unsigned MEM_DEPTH = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic [7:0]  rx_data_i,
   input  logic        rx_valid_i,
   output logic        rx_ready_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic        core_rst_o,
   output logic        done_o,
   output logic        err_o
);

   localparam int unsigned IDX_W = $clog2(MEM_DEPTH) + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_DATA,
      S_CSUM,
      S_RUN,
      S_ERR
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [1:0]        r_byte_cnt;
   logic [23:0]       r_shift;
   logic [IDX_W-1:0]  r_count;
   logic [IDX_W-1:0]  r_idx;
   logic [31:0]       r_xor;
   logic              r_we;
   logic [31:0]       r_addr;
   logic [31:0]       r_wdata;

   logic              w_ready;
   logic              w_take;
   logic              w_word_done;
   logic [31:0]       w_word;
   logic              w_last_data;

   assign w_ready     = (r_state == S_HDR) || (r_state == S_DATA) || (r_state == S_CSUM);
   // A byte handshaked alongside start_i is consumed by the source but discarded here
   assign w_take      = rx_valid_i && w_ready && !start_i;
   assign w_word_done = w_take && (r_byte_cnt == 2'd3);
   assign w_word      = {rx_data_i, r_shift};
   assign w_last_data = ((r_idx + IDX_W'(1)) == r_count);

   always_comb begin
      w_state_nxt = r_state;
      if (start_i) begin
         w_state_nxt = S_HDR;
      end else begin
         case (r_state)
            S_HDR: begin
               if (w_word_done) begin
                  if (w_word > 32'(MEM_DEPTH))
                     w_state_nxt = S_ERR;
                  else if (w_word == '0)
                     w_state_nxt = S_CSUM;
                  else
                     w_state_nxt = S_DATA;
               end
            end
            S_DATA: begin
               if (w_word_done && w_last_data)
                  w_state_nxt = S_CSUM;
            end
            S_CSUM: begin
               if (w_word_done)
                  w_state_nxt = (w_word == r_xor) ? S_RUN : S_ERR;
            end
            default: w_state_nxt = r_state;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_byte_cnt <= '0;
         r_shift    <= '0;
         r_count    <= '0;
         r_idx      <= '0;
         r_xor      <= '0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_we    <= 1'b0;
         if (start_i) begin
            r_byte_cnt <= '0;
            r_shift    <= '0;
            r_idx      <= '0;
            r_xor      <= '0;
         end else if (w_take) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_shift    <= {rx_data_i, r_shift[23:8]};
            if (w_word_done) begin
               case (r_state)
                  S_HDR:  r_count <= w_word[IDX_W-1:0];
                  S_DATA: begin
                     r_we    <= 1'b1;
                     r_addr  <= 32'({r_idx, 2'b00});
                     r_wdata <= w_word;
                     r_xor   <= r_xor ^ w_word;
                     r_idx   <= r_idx + IDX_W'(1);
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   assign rx_ready_o  = w_ready;
   assign mem_we_o    = r_we;
   assign mem_addr_o  = r_addr;
   assign mem_wdata_o = r_wdata;
   assign core_rst_o  = (r_state != S_RUN);
   assign done_o      = (r_state == S_RUN);
   assign err_o       = (r_state == S_ERR);

endmodule

// File: doc/boot_loader_ctrl.md
# boot_loader_ctrl

Boot controller that sequences the instruction memory and the core at start-up. It receives a program image as a byte stream (e.g. from a UART receiver), assembles little-endian 32-bit words, and writes them into the instruction memory's write port. It verifies an XOR checksum and only then releases the core from reset. It sits in the SoC top between the byte source, the instruction memory write port and the core's reset input.

## Interface
Parameters:
- MEM_DEPTH, default 4096: instruction memory capacity in 32-bit words; largest legal word count.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start_i  input  1  one-cycle pulse; begins or restarts a load.
- rx_data_i  input  8  stream byte.
- rx_valid_i  input  1  rx_data_i valid.
- rx_ready_o  output  1  controller can accept a byte.
- mem_we_o  output  1  instruction memory write enable, one-cycle pulse per word.
- mem_addr_o  output  32  byte address of the write, equal to word_index×4.
- mem_wdata_o  output  32  word being written.
- core_rst_o  output  1  synchronous active-high reset to the core.
- done_o  output  1  high while in RUN.
- err_o  output  1  high while in ERR.

## Operation
- Byte accepted ⇔ rx_valid_i && rx_ready_o at a clock edge. rx_ready_o is decoded from the registered state: 1 in HDR, DATA and CSUM; 0 otherwise.
- Image format, all fields little-endian (first byte = bits 7:0):
  - 4-byte header: word count N, 32 bits.
  - N data words, 4 bytes each.
  - 4-byte checksum: XOR of all N data words (0 when N=0).
- States and transitions:
  - IDLE. Reset state. start_i → HDR.
  - HDR. Collects 4 bytes. On the 4th byte:
    - N > MEM_DEPTH → ERR.
    - N = 0 → CSUM.
    - otherwise → DATA.
  - DATA. Collects words. On the 4th byte of each word, the registered write fires (see Timing) and the XOR accumulator is updated. After word N → CSUM.
  - CSUM. Collects 4 bytes. On the 4th byte: match → RUN; mismatch → ERR.
  - RUN. core_rst_o=0, done_o=1. start_i → HDR (core reset reasserted).
  - ERR. err_o=1, core_rst_o=1. start_i → HDR.
- start_i while in HDR, DATA or CSUM aborts the current load and returns to HDR.
  - Byte counter, word index and XOR accumulator are cleared.
  - A byte accepted in the same cycle as start_i is consumed and discarded.
  - start_i has priority over byte accumulation in every state.
- Entering HDR from any state clears the byte counter, word index and accumulator. mem_we_o is not pulsed for any partial word.
- Counters:
  - Byte-in-word counter: 2 bits, wraps 3→0.
  - Word index: log2(MEM_DEPTH)+1 bits, so N=MEM_DEPTH is reachable.
  - Address = index zero-extended, shifted left by 2.

## Timing
- Reset values (cycle after rst high):
  - State IDLE.
  - rx_ready_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
  - core_rst_o=1, done_o=0, err_o=0.
- rst asserted mid-load: same behaviour as above; the partially written image is abandoned.
- Write latency: mem_we_o, mem_addr_o and mem_wdata_o are registered.
  - mem_we_o is high exactly one cycle, in the cycle after the edge that accepted the word's 4th byte.
  - mem_addr_o and mem_wdata_o hold their values until the next write.
- Byte acceptance continues during the write cycle. Full throughput is one byte per clock; there are no stall cycles.
- Back-pressure: the source may drop rx_valid_i at any cycle. The controller holds the partial word indefinitely; there is no timeout.
- Release: state RUN, and therefore core_rst_o=0 and done_o=1, is registered on the edge accepting the last checksum byte. The final data write occurs at least 4 cycles earlier, so memory is always written before the core leaves reset.
- ERR is entered on the edge accepting the offending byte; err_o=1 from the next cycle.
- start_i in RUN: state becomes HDR and core_rst_o=1 from the next cycle.

## Test plan
- Normal load:
  - Stimulus: start_i, then bytes 02 00 00 00 | 13 05 10 00 | 93 05 20 00 | 80 00 30 00.
  - Required: writes 0x00100513 @0x0 and 0x00200593 @0x4; then done_o=1 and core_rst_o=0 on the cycle after the last byte.
- Empty image:
  - Stimulus: header 00 00 00 00, checksum 00 00 00 00.
  - Required: no mem_we_o pulse; RUN reached.
  - Same with checksum 01 00 00 00 → err_o=1, core_rst_o stays 1.
- Oversize:
  - Stimulus: MEM_DEPTH=4, header N=5.
  - Required: err_o=1 right after the 4th header byte; rx_ready_o=0; start_i afterwards → HDR with err_o=0.
- Bad checksum:
  - Stimulus: normal load with checksum 81 00 30 00.
  - Required: both words written, err_o=1, done_o=0, core_rst_o=1.
- Abort and reload:
  - Stimulus: start_i after 2 bytes of word 1 (same cycle as a valid byte), then a full 1-word image.
  - Required: the only write is @0x0 with the new word; success.
  - Also: start_i in RUN → core_rst_o=1 on the next cycle.
- Back-pressure:
  - Stimulus: normal load with rx_valid_i toggled pseudo-randomly (≥50% idle).
  - Required: identical writes and addresses, one mem_we_o pulse per word; rst mid-DATA → IDLE with all reset values.
